// File: rtl/dmem_mmio_ctrl.sv
// Data-side memory controller: routes core loads/stores to block RAM or UART MMIO registers.
// Latency: reads return on mem_dout one cycle after the request; dmem_* drive is combinational.
// Backpressure: mem_hold stalls a UART TX store while the TX FIFO is full; tx_valid/tx_ready drains it.
`timescale 1ns/1ps
module dmem_mmio_ctrl #(
   parameter int          DMEM_ADDR_W = 12,
   parameter int          TX_DEPTH    = 16,
   parameter logic [31:0] MMIO_TX     = 32'h8000_0000,
   parameter logic [31:0] MMIO_RX     = 32'h8000_0004,
   parameter logic [31:0] MMIO_STAT   = 32'h8000_0008
) (
   input  logic                   clk,
   input  logic                   Rst,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_din,
   input  logic [3:0]             mem_en,
   input  logic                   mem_wea,
   input  logic                   mem_rea,
   output logic [31:0]            mem_dout,
   output logic                   mem_hold,
   output logic                   dmem_en,
   output logic [3:0]             dmem_we,
   output logic [DMEM_ADDR_W-1:0] dmem_addr,
   output logic [31:0]            dmem_din,
   input  logic [31:0]            dmem_dout,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid
);

   localparam int PTR_W = $clog2(TX_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Request decode; a simultaneous read+write is treated as a write.
   logic req, wr_req, rd_req, is_mmio;
   logic hit_tx, hit_rx, hit_stat;

   assign req      = (mem_wea | mem_rea) & (mem_en != 4'b0);
   assign wr_req   = req & mem_wea;
   assign rd_req   = req & mem_rea & ~mem_wea;
   assign is_mmio  = mem_addr[31];
   assign hit_tx   = is_mmio & (mem_addr == MMIO_TX);
   assign hit_rx   = is_mmio & (mem_addr == MMIO_RX);
   assign hit_stat = is_mmio & (mem_addr == MMIO_STAT);

   // Block RAM drive; upper address bits are dropped so DMEM aliases.
   assign dmem_en   = req & ~is_mmio;
   assign dmem_we   = mem_wea ? mem_en : 4'b0;
   assign dmem_addr = mem_addr[DMEM_ADDR_W+1:2];
   assign dmem_din  = mem_din;

   // TX FIFO state.
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] tx_cnt;
   logic             tx_full, tx_empty, wr_tx, push, pop;

   assign tx_full  = (tx_cnt == CNT_W'(TX_DEPTH));
   assign tx_empty = (tx_cnt == '0);
   assign wr_tx    = wr_req & hit_tx;
   assign mem_hold = wr_tx & tx_full;
   assign push     = wr_tx & mem_en[0] & ~tx_full;
   assign pop      = ~tx_empty & tx_ready;
   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_mem[rd_ptr];

   // FIFO storage needs no reset; only occupied entries are ever presented.
   always_ff @(posedge clk) begin
      if (push)
         tx_mem[wr_ptr] <= mem_din[7:0];
   end

   // FIFO pointers and occupancy; simultaneous push/pop leaves the count alone.
   always_ff @(posedge clk) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         tx_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   tx_cnt <= tx_cnt + 1'b1;
            2'b01:   tx_cnt <= tx_cnt - 1'b1;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // RX holding register.
   logic [7:0] rx_buf;
   logic       rx_full, rx_ovr, rd_rx, rd_stat, ovr_set;

   assign rd_rx   = rd_req & hit_rx;
   assign rd_stat = rd_req & hit_stat;
   // A byte arriving while full is lost unless a read drains the buffer that same cycle.
   assign ovr_set = rx_valid & rx_full & ~rd_rx;

   // Capture incoming bytes; a status read clears overrun unless a new one lands now.
   always_ff @(posedge clk) begin
      if (Rst) begin
         rx_buf  <= 8'h00;
         rx_full <= 1'b0;
         rx_ovr  <= 1'b0;
      end else begin
         if (rx_valid && (!rx_full || rd_rx)) begin
            rx_buf  <= rx_data;
            rx_full <= 1'b1;
         end else if (rd_rx) begin
            rx_full <= 1'b0;
         end
         if (ovr_set)
            rx_ovr <= 1'b1;
         else if (rd_stat)
            rx_ovr <= 1'b0;
      end
   end

   // MMIO read mux, sampled from pre-update state in the request cycle.
   logic [31:0] mmio_rdata;
   always_comb begin
      mmio_rdata = 32'h0;
      if (hit_rx && rx_full)
         mmio_rdata = {24'h0, rx_buf};
      else if (hit_stat)
         mmio_rdata = {27'h0, rx_ovr, rx_full, tx_full, tx_empty, 1'b0};
   end

   // Read return path: remember which source answers next cycle, and hold the last result.
   logic        rd_vld, rd_dmem;
   logic [31:0] mmio_q, dout_q;

   assign mem_dout = rd_vld ? (rd_dmem ? dmem_dout : mmio_q) : dout_q;

   // Register read-select and keep mem_dout stable between reads.
   always_ff @(posedge clk) begin
      if (Rst) begin
         rd_vld  <= 1'b0;
         rd_dmem <= 1'b0;
         mmio_q  <= 32'h0;
         dout_q  <= 32'h0;
      end else begin
         rd_vld  <= rd_req;
         rd_dmem <= rd_req & ~is_mmio;
         if (rd_req && is_mmio)
            mmio_q <= mmio_rdata;
         if (rd_vld)
            dout_q <= mem_dout;
      end
   end

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Bench for dmem_mmio_ctrl: directed scenarios then random traffic against a queue/array model.
// Latency: model predicts mem_dout one cycle after each read.
// Backpressure: the bench re-presents a request unchanged while the model predicts a hold.
`timescale 1ns/1ps
module tb_dmem_mmio_ctrl;
   localparam int          DEPTH  = 16;
   localparam logic [31:0] A_TX   = 32'h8000_0000;
   localparam logic [31:0] A_RX   = 32'h8000_0004;
   localparam logic [31:0] A_STAT = 32'h8000_0008;
   localparam logic [31:0] A_UNM  = 32'h8000_000C;

   logic        clk, Rst;
   logic [31:0] mem_addr, mem_din, mem_dout, dmem_din, dmem_dout;
   logic [3:0]  mem_en, dmem_we;
   logic        mem_wea, mem_rea, mem_hold, dmem_en;
   logic [11:0] dmem_addr;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid;

   dmem_mmio_ctrl dut (
      .clk(clk), .Rst(Rst), .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en),
      .mem_wea(mem_wea), .mem_rea(mem_rea), .mem_dout(mem_dout), .mem_hold(mem_hold),
      .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
      .dmem_dout(dmem_dout), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural block RAM with one-cycle registered read.
   logic [31:0] bram [0:4095];
   logic        bram_clr;
   always @(posedge clk) begin
      if (bram_clr) begin
         for (int i = 0; i < 4096; i++) bram[i] <= 32'h0;
      end else if (dmem_en) begin
         for (int b = 0; b < 4; b++)
            if (dmem_we[b]) bram[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
         dmem_dout <= bram[dmem_addr];
      end
   end

   // Reference model state.
   logic [31:0] exp_mem [0:4095];
   logic [7:0]  tx_q [$];
   logic [7:0]  out_log [$];
   logic [7:0]  rx_buf_m;
   logic        rx_full_m, rx_ovr_m, last_hold;
   logic [31:0] dout_m;
   int          checks, errors;

   // Values seen at the most recent sampling point.
   logic        obs_hold, obs_txv;
   logic [3:0]  obs_we;
   logic [31:0] obs_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: apply inputs, check at negedge, advance the model, step past posedge.
   task automatic cyc(input logic rst, input logic wea, input logic rea, input logic [31:0] addr,
                      input logic [31:0] din, input logic [3:0] en, input logic txr,
                      input logic rxv, input logic [7:0] rxd);
      logic        req, wr, rd, mm, exp_hold, pop, push, ovr;
      logic [31:0] rval;
      int          idx;
      Rst = rst; mem_wea = wea; mem_rea = rea; mem_addr = addr; mem_din = din;
      mem_en = en; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
      req  = (wea || rea) && (en != 4'h0);
      wr   = req && wea;
      rd   = req && rea && !wea;
      mm   = addr[31];
      idx  = int'(addr[13:2]);
      exp_hold = wr && (addr == A_TX) && (tx_q.size() == DEPTH);
      @(negedge clk);
      obs_hold = mem_hold; obs_txv = tx_valid; obs_we = dmem_we; obs_addr = 32'(dmem_addr);
      if (!rst) begin
         chk("hold", mem_hold, exp_hold);
         chk("dmem_en", dmem_en, req && !mm);
         chk("dmem_we", dmem_we, wea ? en : 4'h0);
         chk("dmem_addr", 32'(dmem_addr), 32'(addr[13:2]));
         chk("dmem_din", dmem_din, din);
         chk("tx_valid", tx_valid, tx_q.size() != 0);
         if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
         chk("mem_dout", mem_dout, dout_m);
         if (tx_valid && txr) out_log.push_back(tx_data);
      end
      if (wr && !mm)
         for (int b = 0; b < 4; b++)
            if (en[b]) exp_mem[idx][8*b +: 8] = din[8*b +: 8];
      if (rst) begin
         tx_q.delete();
         rx_full_m = 1'b0; rx_ovr_m = 1'b0; dout_m = 32'h0;
      end else begin
         rval = 32'h0;
         if (!mm) rval = exp_mem[idx];
         else if (addr == A_RX && rx_full_m) rval = {24'h0, rx_buf_m};
         else if (addr == A_STAT)
            rval = {27'h0, rx_ovr_m, rx_full_m, tx_q.size() == DEPTH, tx_q.size() == 0, 1'b0};
         pop  = (tx_q.size() != 0) && txr;
         push = wr && (addr == A_TX) && en[0] && (tx_q.size() < DEPTH);
         if (pop)  void'(tx_q.pop_front());
         if (push) tx_q.push_back(din[7:0]);
         ovr = 1'b0;
         if (rxv) begin
            if (!rx_full_m)              begin rx_buf_m = rxd; rx_full_m = 1'b1; end
            else if (rd && addr == A_RX) rx_buf_m = rxd;
            else                         ovr = 1'b1;
         end else if (rd && addr == A_RX) rx_full_m = 1'b0;
         if (ovr) rx_ovr_m = 1'b1;
         else if (rd && addr == A_STAT) rx_ovr_m = 1'b0;
         if (rd) dout_m = rval;
      end
      last_hold = exp_hold;
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic txr);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, txr, 1'b0, 8'h00);
   endtask

   task automatic rd32(input logic [31:0] a);
      cyc(1'b0, 1'b0, 1'b1, a, 32'h0, 4'hF, 1'b0, 1'b0, 8'h00);
   endtask

   logic        r_wea, r_rea, r_txr, r_rxv, r_rst;
   logic [31:0] r_addr, r_din;
   logic [3:0]  r_en;
   logic [7:0]  r_rxd;

   initial begin
      checks = 0; errors = 0;
      for (int i = 0; i < 4096; i++) exp_mem[i] = 32'h0;
      rx_buf_m = 8'h00; rx_full_m = 1'b0; rx_ovr_m = 1'b0; dout_m = 32'h0; last_hold = 1'b0;
      bram_clr = 1'b1;
      Rst = 1'b1; mem_wea = 1'b0; mem_rea = 1'b0; mem_addr = 32'h0; mem_din = 32'h0;
      mem_en = 4'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      @(posedge clk); #1;
      bram_clr = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00);

      // Reset state.
      idle(1'b0);
      chk("rst_dout", mem_dout, 32'h0);
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_hold", mem_hold, 1'b0);

      // DMEM store/load, byte store, aliasing.
      cyc(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 8'h00);
      chk("st_we", obs_we, 4'hF);
      chk("st_addr", obs_addr, 32'd4);
      rd32(32'h0000_0010);
      chk("ld_word", mem_dout, 32'hDEAD_BEEF);
      cyc(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_AB00, 4'b0010, 1'b0, 1'b0, 8'h00);
      chk("stb_we", obs_we, 4'b0010);
      rd32(32'h0000_4010);
      chk("alias_addr", obs_addr, 32'd4);
      chk("ld_byte", mem_dout, 32'hDEAD_ABEF);
      idle(1'b0);
      chk("dout_kept", mem_dout, 32'hDEAD_ABEF);

      // TX stream with the transmitter always ready.
      out_log.delete();
      cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h41, 4'h1, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h42, 4'h1, 1'b1, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h43, 4'h1, 1'b1, 1'b0, 8'h00);
      idle(1'b1);
      idle(1'b1);
      chk("tx_n", out_log.size(), 3);
      if (out_log.size() == 3) begin
         chk("tx0", out_log[0], 8'h41);
         chk("tx1", out_log[1], 8'h42);
         chk("tx2", out_log[2], 8'h43);
      end
      chk("tx_drained", tx_valid, 1'b0);
      rd32(A_STAT);
      chk("stat_empty", mem_dout, 32'h2);

      // RX capture and overrun.
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 8'h5A);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 8'h33);
      rd32(A_RX);
      chk("rx_5a", mem_dout, 32'h5A);
      rd32(A_STAT);
      chk("stat_ovr", mem_dout, 32'h12);
      rd32(A_STAT);
      chk("stat_ovr_clr", mem_dout[4], 1'b0);

      // RX read racing a new byte while full.
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 8'h11);
      cyc(1'b0, 1'b0, 1'b1, A_RX, 32'h0, 4'hF, 1'b0, 1'b1, 8'h77);
      chk("rx_old", mem_dout, 32'h11);
      rd32(A_STAT);
      chk("stat_rxfull", mem_dout, 32'h0A);
      rd32(A_RX);
      chk("rx_77", mem_dout, 32'h77);
      rd32(A_UNM);
      chk("unmapped", mem_dout, 32'h0);

      // TX backpressure.
      out_log.delete();
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h10 + i, 4'h1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h99, 4'h1, 1'b0, 1'b0, 8'h00);
         chk("bp_hold", obs_hold, 1'b1);
      end
      cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h99, 4'h1, 1'b1, 1'b0, 8'h00);
      chk("bp_hold_pop", obs_hold, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h99, 4'h1, 1'b0, 1'b0, 8'h00);
      chk("bp_release", obs_hold, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
      chk("bp_n", out_log.size(), DEPTH + 1);
      if (out_log.size() == DEPTH + 1) begin
         chk("bp_first", out_log[0], 8'h10);
         chk("bp_17th", out_log[DEPTH], 8'h99);
      end

      // Reset while a store is held.
      for (int i = 0; i < DEPTH; i++)
         cyc(1'b0, 1'b1, 1'b0, A_TX, 32'hA0 + i, 4'h1, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b1, 1'b0, A_TX, 32'h55, 4'h1, 1'b0, 1'b0, 8'h00);
      chk("mr_hold", obs_hold, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, A_TX, 32'h55, 4'h1, 1'b0, 1'b0, 8'h00);
      rd32(A_STAT);
      chk("mr_hold_off", obs_hold, 1'b0);
      chk("mr_txv", obs_txv, 1'b0);
      chk("mr_stat", mem_dout, 32'h2);

      // Random traffic; a held request is re-presented unchanged.
      r_wea = 1'b0; r_rea = 1'b0; r_addr = 32'h0; r_din = 32'h0; r_en = 4'h0;
      for (int n = 0; n < 600; n++) begin
         if (!last_hold) begin
            r_wea = 1'($urandom_range(0, 1));
            r_rea = 1'($urandom_range(0, 1));
            r_din = $urandom;
            r_en  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
               0, 1, 2, 3: r_addr = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 15)) << 2);
               4, 5:       r_addr = A_TX;
               6:          r_addr = ($urandom_range(0, 1) == 0) ? A_RX : A_STAT;
               default:    r_addr = A_UNM;
            endcase
         end
         r_txr = ($urandom_range(0, 3) == 0);
         r_rxv = ($urandom_range(0, 3) == 0);
         r_rxd = 8'($urandom);
         r_rst = ($urandom_range(0, 199) == 0);
         cyc(r_rst, r_wea, r_rea, r_addr, r_din, r_en, r_txr, r_rxv, r_rxd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
